// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic DEPTH-entry pipeline stage with valid/ready handshake and flush
// in_ready is derived only from registered occupancy, so chained stages have no ready loop.
module pipe_stage_elastic #(
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 2,
   parameter logic [DATA_W-1:0] FLUSH_VAL = DATA_W'(32'h0000_0013),
   parameter int                CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  occupancy
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;
   logic [PTR_W-1:0]  wr_ptr_inc;
   logic [PTR_W-1:0]  rd_ptr_inc;

   assign in_ready  = (count < FULL_CNT);
   assign out_valid = (count != '0);
   assign occupancy = count;
   assign out_data  = out_valid ? mem[rd_ptr] : FLUSH_VAL;

   // Flush suppresses both handshakes so neither side sees a transfer that cycle.
   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   // Explicit wrap keeps non-power-of-two depths legal.
   assign wr_ptr_inc = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
   assign rd_ptr_inc = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr_inc;
         end
         if (pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; out_data masks it with FLUSH_VAL whenever empty.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= in_data;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for pipe_stage_elastic at DEPTH 2, 3 and 1
module tb_pipe_stage_elastic;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        fl2, iv2, ir2, ov2, or2;
   logic [31:0] id2, od2;
   logic [1:0]  occ2;
   logic        fl3, iv3, ir3, ov3, or3;
   logic [31:0] id3, od3;
   logic [1:0]  occ3;
   logic        fl1, iv1, ir1, ov1, or1;
   logic [31:0] id1, od1;
   logic [0:0]  occ1;

   pipe_stage_elastic #(.DATA_W(32), .DEPTH(2), .FLUSH_VAL(32'h13)) u_d2 (
      .clk(clk), .rst(rst), .flush(fl2), .in_valid(iv2), .in_data(id2), .in_ready(ir2),
      .out_valid(ov2), .out_data(od2), .out_ready(or2), .occupancy(occ2));
   pipe_stage_elastic #(.DATA_W(32), .DEPTH(3), .FLUSH_VAL(32'h13)) u_d3 (
      .clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3), .in_data(id3), .in_ready(ir3),
      .out_valid(ov3), .out_data(od3), .out_ready(or3), .occupancy(occ3));
   pipe_stage_elastic #(.DATA_W(32), .DEPTH(1), .FLUSH_VAL(32'h13)) u_d1 (
      .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
      .out_valid(ov1), .out_data(od1), .out_ready(or1), .occupancy(occ1));

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic        e_ov;
      logic [31:0] e_od;
      logic        e_ir;
      logic [1:0]  e_occ;
   } vec_t;

   localparam int NVEC = 27;
   vec_t vecs [NVEC];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] id, input logic o,
                               input logic eov, input logic [31:0] eod, input logic eir,
                               input logic [1:0] eocc);
      vec_t v;
      v.fl = fl; v.iv = iv; v.id = id; v.ordy = o;
      v.e_ov = eov; v.e_od = eod; v.e_ir = eir; v.e_occ = eocc;
      return v;
   endfunction

   logic        hold_p;
   logic [31:0] hold_v;
   int          nxt, expv, cyc;

   initial begin
      // Expected outputs are those seen during the cycle, before the edge that consumes the inputs.
      vecs[0]  = mk(0, 0, 32'h0,    0, 0, 32'h13,  1, 0);
      vecs[1]  = mk(0, 0, 32'h0,    0, 0, 32'h13,  1, 0);
      vecs[2]  = mk(0, 0, 32'h0,    0, 0, 32'h13,  1, 0);
      vecs[3]  = mk(0, 0, 32'h0,    0, 0, 32'h13,  1, 0);
      vecs[4]  = mk(0, 0, 32'h0,    0, 0, 32'h13,  1, 0);
      vecs[5]  = mk(0, 1, 32'h100,  1, 0, 32'h13,  1, 0);
      vecs[6]  = mk(0, 1, 32'h104,  1, 1, 32'h100, 1, 1);
      vecs[7]  = mk(0, 1, 32'h108,  1, 1, 32'h104, 1, 1);
      vecs[8]  = mk(0, 1, 32'h10C,  1, 1, 32'h108, 1, 1);
      vecs[9]  = mk(0, 0, 32'h0,    1, 1, 32'h10C, 1, 1);
      vecs[10] = mk(0, 0, 32'h0,    0, 0, 32'h13,  1, 0);
      vecs[11] = mk(0, 1, 32'hA0,   0, 0, 32'h13,  1, 0);
      vecs[12] = mk(0, 1, 32'hB0,   0, 1, 32'hA0,  1, 1);
      vecs[13] = mk(0, 1, 32'hC0,   0, 1, 32'hA0,  0, 2);
      vecs[14] = mk(0, 1, 32'hC0,   0, 1, 32'hA0,  0, 2);
      vecs[15] = mk(0, 1, 32'hC0,   1, 1, 32'hA0,  0, 2);
      vecs[16] = mk(0, 1, 32'hC0,   1, 1, 32'hB0,  1, 1);
      vecs[17] = mk(0, 0, 32'h0,    1, 1, 32'hC0,  1, 1);
      vecs[18] = mk(0, 0, 32'h0,    0, 0, 32'h13,  1, 0);
      vecs[19] = mk(0, 1, 32'h11,   0, 0, 32'h13,  1, 0);
      vecs[20] = mk(0, 1, 32'h22,   0, 1, 32'h11,  1, 1);
      vecs[21] = mk(1, 1, 32'hDEAD, 0, 1, 32'h11,  0, 2);
      vecs[22] = mk(0, 0, 32'h0,    0, 0, 32'h13,  1, 0);
      vecs[23] = mk(0, 1, 32'h33,   1, 0, 32'h13,  1, 0);
      vecs[24] = mk(1, 1, 32'hDEAD, 1, 1, 32'h33,  1, 1);
      vecs[25] = mk(0, 0, 32'h0,    1, 0, 32'h13,  1, 0);
      vecs[26] = mk(0, 0, 32'h0,    0, 0, 32'h13,  1, 0);

      rst = 1'b1;
      {fl2, iv2, or2, fl3, iv3, or3, fl1, iv1, or1} = '0;
      id2 = '0; id3 = '0; id1 = '0;
      hold_p = 1'b0; hold_v = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         @(posedge clk);
         #1;
         fl2 = vecs[i].fl; iv2 = vecs[i].iv; id2 = vecs[i].id; or2 = vecs[i].ordy;
         #1;
         chk($sformatf("v%0d out_valid", i), 32'(ov2), 32'(vecs[i].e_ov));
         chk($sformatf("v%0d out_data", i), od2, vecs[i].e_od);
         chk($sformatf("v%0d in_ready", i), 32'(ir2), 32'(vecs[i].e_ir));
         chk($sformatf("v%0d occupancy", i), 32'(occ2), 32'(vecs[i].e_occ));
         if (hold_p) chk($sformatf("v%0d stall_stable", i), od2, hold_v);
         hold_p = ov2 & ~or2 & ~fl2;
         hold_v = od2;
      end

      // Reset wins over a pending push with a full buffer.
      @(posedge clk); #1;
      fl2 = 0; iv2 = 1; id2 = 32'hAA; or2 = 0;
      @(posedge clk); #1;
      id2 = 32'hAB;
      @(posedge clk); #1;
      chk("rst_pre occupancy", 32'(occ2), 32'd2);
      rst = 1'b1; id2 = 32'hBB;
      @(posedge clk); #1;
      rst = 1'b0; iv2 = 0;
      #1;
      chk("rst out_valid", 32'(ov2), 32'd0);
      chk("rst out_data", od2, 32'h13);
      chk("rst in_ready", 32'(ir2), 32'd1);
      chk("rst occupancy", 32'(occ2), 32'd0);

      // DEPTH=3 wrap with random stalls: order must be 1..10.
      nxt = 1; expv = 1; cyc = 0;
      while (expv <= 10 && cyc < 300) begin
         @(posedge clk); #1;
         iv3 = (nxt <= 10); id3 = 32'(nxt); or3 = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (occ3 > 2'd3 || $isunknown(occ3)) begin
            failures++;
            $display("FAIL d3 occupancy_bound: got %0d expected <= 3", occ3);
         end
         if (iv3 && ir3) nxt++;
         if (ov3 && or3) begin
            chk($sformatf("d3 order%0d", expv), od3, 32'(expv));
            expv++;
         end
         cyc++;
      end
      if (expv <= 10) begin
         failures++;
         $display("FAIL d3 timeout: got %0d beats expected 10", expv - 1);
      end
      @(posedge clk); #1;
      iv3 = 0; or3 = 1;
      repeat (4) @(posedge clk);
      #1;
      chk("d3 drained occupancy", 32'(occ3), 32'd0);

      // DEPTH=1 half-rate: accepts on even cycles, presents on odd cycles.
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         iv1 = 1; id1 = 32'(k / 2 + 1); or1 = 1;
         #1;
         chk($sformatf("d1 k%0d in_ready", k), 32'(ir1), 32'((k % 2) == 0));
         chk($sformatf("d1 k%0d out_valid", k), 32'(ov1), 32'((k % 2) == 1));
         chk($sformatf("d1 k%0d out_data", k), od1, ((k % 2) == 1) ? 32'(k / 2 + 1) : 32'h13);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic pipeline-stage register for the CPU front/back end.
- Replaces fixed per-stage registers (e.g. IF/ID) with a generic DEPTH-entry buffered stage.
- Carries an arbitrary DATA_W payload bundle (PC, instruction, prediction fields packed by the instantiator).
- Uses a valid/ready handshake instead of a bare write-enable, and supports flush with a configurable bubble value.
- Ready is registered-only, so there is no combinational path from out_ready to in_ready; this lets stages be chained without timing loops.

Parameters:
- DATA_W, 32: payload width in bits, >= 1.
- DEPTH, 2: buffer entries, 1..8. DEPTH >= 2 is required for one beat per cycle.
- FLUSH_VAL, 32'h0000_0013: payload driven on out_data when no valid entry (NOP bubble). Width DATA_W, zero-extended or truncated.
- CNT_W, $clog2(DEPTH+1): width of the occupancy output. Derived; must not be overridden.

Ports:
- clk        in   1       clock, rising edge
- rst        in   1       reset, synchronous, active-high
- flush      in   1       discard all buffered and incoming beats this cycle
- in_valid   in   1       upstream beat present
- in_data    in   DATA_W  upstream payload
- in_ready   out  1       stage can accept a beat this cycle
- out_valid  out  1       head entry valid
- out_data   out  DATA_W  head payload; FLUSH_VAL when out_valid=0
- out_ready  in   1       downstream accepts head (0 = stall/hold)
- occupancy  out  CNT_W   number of valid entries, 0..DEPTH

Behaviour:
- Reset (rst=1 at posedge):
  - occupancy=0, read/write pointers=0.
  - out_valid=0, out_data=FLUSH_VAL, in_ready=1.
  - Storage contents are don't-care.
  - rst has priority over flush and over all handshakes.
- Derived signals:
  - in_ready = (occupancy < DEPTH). Driven from registered state only; independent of out_ready and flush.
  - out_valid = (occupancy != 0).
  - out_data = entry[rd_ptr] when out_valid=1, else FLUSH_VAL. Combinational mux of registered storage.
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
- Per-edge update:
  - push writes in_data at wr_ptr.
  - wr_ptr advances on push; rd_ptr advances on pop.
  - occupancy += push - pop. Push and pop in the same cycle leave occupancy unchanged.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 explicitly, so non-power-of-2 DEPTH is legal.
- Latency:
  - A beat pushed at edge N is visible on out_* after edge N (1 cycle), provided it is at the head.
  - No same-cycle pass-through from in_data to out_data.
- Full (occupancy == DEPTH):
  - in_ready=0; in_valid is ignored and not an error.
  - A pop in this cycle does not re-enable in_ready until the next cycle.
- Empty (occupancy == 0):
  - out_valid=0; out_ready is ignored.
- Stall (out_ready=0, out_valid=1):
  - Head entry and out_data hold stable.
  - Upstream may keep filling until full.
- Flush (flush=1, rst=0):
  - At the edge: occupancy=0 and rd_ptr=wr_ptr=0.
  - The concurrent in_valid beat is dropped, even if in_ready=1.
  - No pop is reported: downstream must not treat out_ready as a consumed beat.
  - From the next cycle: out_valid=0, out_data=FLUSH_VAL.
- Flush while stalled: flush wins, and the stalled head is discarded.
- DEPTH=1:
  - Behaves as a half-rate register: in_ready=0 whenever an entry is held, even if out_ready=1.
  - Must still work correctly at this depth.
- Assertions for the bench:
  - occupancy <= DEPTH always.
  - out_data stable while out_valid & ~out_ready & ~flush.
  - No X on out_valid or in_ready after reset.

Test Plan:
Configuration for all scenarios: DATA_W=32, DEPTH=2, FLUSH_VAL=32'h13 unless stated.
1. Reset then idle -> out_valid=0, out_data=32'h13, in_ready=1, occupancy=0. Holds for 5 cycles with in_valid=0.
2. Streaming: in_valid=1 with in_data=32'h100,104,108,10C on consecutive cycles, out_ready=1 throughout -> out_data shows 100,104,108,10C one cycle after each push. No bubbles; occupancy stays 1.
3. Backpressure:
   - Push A=32'hA0, B=32'hB0 with out_ready=0 -> occupancy=2, in_ready=0. A third beat 32'hC0 is not accepted. out_data=A0 stable.
   - Raise out_ready -> A0 then B0 drain, then C0 is accepted one cycle after in_ready returns to 1.
4. Flush with a full buffer and a concurrent in_valid=1 (in_data=32'hDEAD) -> next cycle occupancy=0, out_valid=0, out_data=32'h13. 32'hDEAD never appears on out_data.
5. Pointer wrap with DEPTH=3: push and pop 10 beats (0x1..0xA) with random out_ready stalls -> output order is exactly 0x1..0xA. occupancy never exceeds 3.
6. DEPTH=1, out_ready=1, in_valid=1 continuously with incrementing data -> one beat accepted every 2 cycles. Order preserved; in_ready toggles 1,0,1,0.
